// File: rtl/move_sequencer.sv
// move_sequencer: command FIFO in front of the motor move block, issuing one command at a time.
// Latency: a write into an empty queue with run=1 raises req two edges later; each completion is followed by RELEASE and GAP.
// Backpressure: writes while full are dropped (err_ovf); the next command waits for done, done low again, and the gap.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   wr_en/wr_op/wr_operand  command push from the host-side decoder
//   run, abort, clr_err controls: dequeue enable, flush + stop, clear sticky errors
//   req/op/operand/done handshake with the move block
//   full/empty/level    queue status;  busy: sequencer not IDLE;  cmd_count: completed commands
//   err_ovf/err_bad_op/err_timeout  sticky error flags
// Optional: define MOVE_TIMEOUT_EN to add the ISSUE watchdog (TIMEOUT_CYCLES); otherwise err_timeout is tied low.
module move_sequencer #(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   wr_en,
  input  logic [2:0]             wr_op,
  input  logic [31:0]            wr_operand,
  input  logic                   run,
  input  logic                   abort,
  input  logic                   clr_err,
  output logic                   req,
  output logic [2:0]             op,
  output logic [31:0]            operand,
  input  logic                   done,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic [15:0]            cmd_count,
  output logic                   err_ovf,
  output logic                   err_bad_op,
  output logic                   err_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [2:0] OP_STOP = 3'd4;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] operand;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_GAP,
    S_ABORT_DROP,
    S_ABORT_STOP
  } state_t;

  state_t        state;
  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          push;
  logic          pop;
  logic          flush;
  // Head entry popped in IDLE is decoded on the following edge.
  logic          fetch_vld;
  cmd_t          fetch_cmd;
  logic [31:0]   gap_cnt;

`ifdef MOVE_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        stop_cmd;   // the command in flight is the abort stop
  logic        tmo_hit;

  assign tmo_hit = (state == S_ISSUE) && !done && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  // A timed-out stop command does not flush; it just gives up.
  assign flush   = abort || (tmo_hit && !stop_cmd);
`else
  assign flush       = abort;
  assign err_timeout = 1'b0;
`endif

  assign push = wr_en && !full && !flush;
  assign pop  = (state == S_IDLE) && !fetch_vld && run && !empty && !abort;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (!push && pop)
      level_nxt = level - 1'b1;
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= {wr_op, wr_operand};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (clr_err)
        err_ovf <= 1'b0;
      if (wr_en && full && !flush)
        err_ovf <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        empty  <= 1'b1;
        full   <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        level <= level_nxt;
        empty <= (level_nxt == '0);
        full  <= (level_nxt == LW'(DEPTH));
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      req        <= 1'b0;
      op         <= '0;
      operand    <= '0;
      busy       <= 1'b0;
      cmd_count  <= '0;
      err_bad_op <= 1'b0;
      fetch_vld  <= 1'b0;
      fetch_cmd  <= '0;
      gap_cnt    <= '0;
`ifdef MOVE_TIMEOUT_EN
      tmo_cnt     <= '0;
      stop_cmd    <= 1'b0;
      err_timeout <= 1'b0;
`endif
    end else begin
      if (clr_err) begin
        err_bad_op <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
        err_timeout <= 1'b0;
`endif
      end
      // Abort wins over everything; once in the abort path it only re-flushes.
      if (abort && (state inside {S_IDLE, S_ISSUE, S_RELEASE, S_GAP})) begin
        fetch_vld <= 1'b0;
        busy      <= 1'b1;
        if (state == S_IDLE) begin
          state <= S_ABORT_STOP;
        end else begin
          req   <= 1'b0;
          state <= S_ABORT_DROP;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (fetch_vld) begin
              fetch_vld <= 1'b0;
              if (fetch_cmd.op <= OP_STOP) begin
                op      <= fetch_cmd.op;
                operand <= fetch_cmd.operand;
                req     <= 1'b1;
                busy    <= 1'b1;
                state   <= S_ISSUE;
`ifdef MOVE_TIMEOUT_EN
                tmo_cnt  <= '0;
                stop_cmd <= 1'b0;
`endif
              end else begin
                err_bad_op <= 1'b1;
              end
            end else if (pop) begin
              fetch_vld <= 1'b1;
              fetch_cmd <= mem[rd_ptr];
            end
          end
          S_ISSUE: begin
            if (done) begin
              req       <= 1'b0;
              cmd_count <= cmd_count + 1'b1;
              state     <= S_RELEASE;
            end
`ifdef MOVE_TIMEOUT_EN
            else if (tmo_hit) begin
              err_timeout <= 1'b1;
              req         <= 1'b0;
              if (stop_cmd) begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                state <= S_ABORT_DROP;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
          S_RELEASE: begin
            // The move block re-arms on a req edge, so done must drop first.
            if (!done) begin
              if (GAP_CYCLES == 0) begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == 32'(GAP_CYCLES - 1)) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          S_ABORT_DROP: begin
            // Entered with req already low, so req stays low at least one cycle.
            if (!done)
              state <= S_ABORT_STOP;
          end
          S_ABORT_STOP: begin
            op      <= OP_STOP;
            operand <= '0;
            req     <= 1'b1;
            state   <= S_ISSUE;
`ifdef MOVE_TIMEOUT_EN
            tmo_cnt  <= '0;
            stop_cmd <= 1'b1;
`endif
          end
          default: begin
            req   <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: randomized and directed stimulus against a queue-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a; a done responder process emulates the move block.
module tb_move_sequencer;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 100;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] opr;
  } cmd_t;

  logic        CLK;
  logic        RST;
  logic        wr_en;
  logic [2:0]  wr_op;
  logic [31:0] wr_operand;
  logic        run;
  logic        abort;
  logic        clr_err;
  logic        req;
  logic [2:0]  op;
  logic [31:0] operand;
  logic        done;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        busy;
  logic [15:0] cmd_count;
  logic        err_ovf;
  logic        err_bad_op;
  logic        err_timeout;

  move_sequencer #(
    .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_op(wr_op), .wr_operand(wr_operand),
    .run(run), .abort(abort), .clr_err(clr_err), .req(req), .op(op), .operand(operand),
    .done(done), .full(full), .empty(empty), .level(level), .busy(busy),
    .cmd_count(cmd_count), .err_ovf(err_ovf), .err_bad_op(err_bad_op), .err_timeout(err_timeout)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   exp_count = 0;
  bit   auto_done;
  bit   rand_dly;
  int   dly;
  cmd_t issued [$];
  cmd_t w_q [$];
  cmd_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Move block model: pulses done for one cycle once req has been high for dly cycles.
  initial begin
    int hi_cnt;
    hi_cnt = 0;
    done = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (done) begin
        done = 1'b0;
        hi_cnt = 0;
      end else if (req && auto_done) begin
        hi_cnt++;
        if (hi_cnt >= dly) begin
          done = 1'b1;
          if (rand_dly) dly = $urandom_range(1, 6);
        end
      end else begin
        hi_cnt = 0;
      end
    end
  end

  // Bus monitor: records issued commands, checks op validity, stability and post-completion gap.
  initial begin
    logic        prev_req;
    logic        unstable;
    logic        saw_done;
    logic        done_fall;
    logic [2:0]  cap_op;
    logic [31:0] cap_opr;
    int          fall_cyc;
    prev_req = 1'b0; unstable = 1'b0; saw_done = 1'b0; done_fall = 1'b0;
    cap_op = '0; cap_opr = '0; fall_cyc = 0;
    forever begin
      @(negedge CLK);
      if (req && !prev_req) begin
        issued.push_back({op, operand});
        check("op_on_bus_valid", 32'(op <= 3'd4), 32'd1);
        if (done_fall)
          check("gap_after_done", 32'((cyc - fall_cyc) >= GAP + 1), 32'd1);
        cap_op = op; cap_opr = operand; unstable = 1'b0; saw_done = 1'b0;
      end else if (req) begin
        if (op !== cap_op || operand !== cap_opr) unstable = 1'b1;
        if (done) saw_done = 1'b1;
      end
      if (!req && prev_req) begin
        check("bus_stable_while_req", 32'(unstable), 32'd0);
        fall_cyc  = cyc;
        done_fall = saw_done;
      end
      prev_req = req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic write_cmd(input logic [2:0] o, input logic [31:0] v);
    wr_en = 1'b1; wr_op = o; wr_operand = v;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic val, input int budget);
    int t;
    t = 0;
    while (req !== val && t < budget) begin
      tick(1);
      t++;
    end
    check(tag, 32'(req), 32'(val));
  endtask

  // Idle means several consecutive quiet cycles, so a popped-but-not-issued entry is not missed.
  task automatic wait_idle(input string tag, input int budget);
    int t;
    int quiet;
    t = 0; quiet = 0;
    while (quiet < 4 && t < budget) begin
      tick(1);
      t++;
      if (!busy && !req && empty) quiet++;
      else quiet = 0;
    end
    check(tag, 32'(quiet >= 4), 32'd1);
  endtask

  // Fill with run=0, check queue status, then drain and compare against the model.
  task automatic run_round(input string tag);
    bit bad;
    int acc;
    run = 1'b0;
    exp_q.delete();
    issued.delete();
    bad = 1'b0;
    foreach (w_q[i]) begin
      write_cmd(w_q[i].op, w_q[i].opr);
      if (i < DEPTH) begin
        if (w_q[i].op <= 3'd4) exp_q.push_back(w_q[i]);
        else bad = 1'b1;
      end
    end
    acc = (w_q.size() < DEPTH) ? w_q.size() : DEPTH;
    check({tag, "_level"}, 32'(level), 32'(acc));
    check({tag, "_full"}, 32'(full), 32'(acc == DEPTH));
    check({tag, "_empty_before"}, 32'(empty), 32'(acc == 0));
    check({tag, "_err_ovf"}, 32'(err_ovf), 32'(w_q.size() > DEPTH));
    run = 1'b1;
    wait_idle({tag, "_drain"}, 40 * (DEPTH + 2));
    exp_count += exp_q.size();
    check({tag, "_issued_n"}, 32'(issued.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < issued.size()) begin
        check({tag, "_op"}, 32'(issued[i].op), 32'(exp_q[i].op));
        check({tag, "_operand"}, issued[i].opr, exp_q[i].opr);
      end
    end
    check({tag, "_cmd_count"}, 32'(cmd_count), 32'(exp_count % 65536));
    check({tag, "_err_bad_op"}, 32'(err_bad_op), 32'(bad));
    check({tag, "_empty_after"}, 32'(empty), 32'd1);
    pulse_clr();
    check({tag, "_clr_ovf"}, 32'(err_ovf), 32'd0);
    check({tag, "_clr_bad"}, 32'(err_bad_op), 32'd0);
    run = 1'b0;
  endtask

  initial begin
    RST = 1'b1; wr_en = 1'b0; wr_op = '0; wr_operand = '0;
    run = 1'b0; abort = 1'b0; clr_err = 1'b0;
    auto_done = 1'b1; rand_dly = 1'b0; dly = 5;
    tick(3);
    check("rst_req", 32'(req), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_operand", operand, 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    check("rst_errs", 32'({err_ovf, err_bad_op, err_timeout}), 32'd0);
    RST = 1'b0;
    tick(2);

    // Single command: req two edges after the write edge.
    run = 1'b1;
    issued.delete();
    write_cmd(3'd0, 32'd1000);
    check("lat_edge_n", 32'(req), 32'd0);
    tick(1);
    check("lat_edge_n1", 32'(req), 32'd0);
    tick(1);
    check("lat_edge_n2", 32'(req), 32'd1);
    check("single_op", 32'(op), 32'd0);
    check("single_operand", operand, 32'd1000);
    wait_req("single_fall", 1'b0, 30);
    exp_count = 1;
    check("single_cmd_count", 32'(cmd_count), 32'd1);
    write_cmd(3'd3, 32'd77);
    wait_req("second_rise", 1'b1, 60);
    check("second_op", 32'(op), 32'd3);
    wait_idle("second_idle", 100);
    exp_count = 2;
    check("second_cmd_count", 32'(cmd_count), 32'd2);
    run = 1'b0;

    // Overfill with nine valid commands.
    w_q.delete();
    for (int i = 0; i < 9; i++) w_q.push_back({3'(i % 5), 32'(100 + i)});
    run_round("full");

    // Invalid op ahead of a valid one.
    w_q.delete();
    w_q.push_back({3'd6, 32'd9});
    w_q.push_back({3'd1, 32'd50});
    run_round("badop");

    // Randomized rounds.
    rand_dly = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 12);
      w_q.delete();
      for (int i = 0; i < n; i++) w_q.push_back({3'($urandom_range(0, 7)), $urandom});
      run_round($sformatf("rnd%0d", r));
    end
    rand_dly = 1'b0;
    dly = 3;

    // Abort during the first of three commands.
    issued.delete();
    w_q.delete();
    for (int i = 0; i < 3; i++) begin
      w_q.push_back({3'($urandom_range(0, 4)), $urandom});
      write_cmd(w_q[i].op, w_q[i].opr);
    end
    auto_done = 1'b0;
    run = 1'b1;
    wait_req("abort_first_rise", 1'b1, 20);
    check("abort_level_before", 32'(level), 32'd2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_req_dropped", 32'(req), 32'd0);
    check("abort_level_flushed", 32'(level), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    wait_req("abort_stop_rise", 1'b1, 20);
    check("abort_stop_op", 32'(op), 32'd4);
    check("abort_stop_operand", operand, 32'd0);
    auto_done = 1'b1;
    wait_idle("abort_idle", 100);
    exp_count += 1;
    check("abort_issued_n", 32'(issued.size()), 32'd2);
    if (issued.size() >= 1) check("abort_first_op", 32'(issued[0].op), 32'(w_q[0].op));
    check("abort_cmd_count", 32'(cmd_count), 32'(exp_count % 65536));
    check("abort_busy_after", 32'(busy), 32'd0);

    // Abort while idle goes straight to the stop command.
    issued.delete();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_req("abort_idle_stop", 1'b1, 10);
    check("abort_idle_op", 32'(op), 32'd4);
    wait_idle("abort_idle_done", 100);
    exp_count += 1;
    check("abort_idle_count", 32'(cmd_count), 32'(exp_count % 65536));
    run = 1'b0;

`ifdef MOVE_TIMEOUT_EN
    begin
      int t0;
      issued.delete();
      auto_done = 1'b0;
      run = 1'b1;
      write_cmd(3'd2, 32'd555);
      wait_req("tmo_rise", 1'b1, 20);
      t0 = cyc;
      wait_req("tmo_fall", 1'b0, 3 * TMO);
      check("tmo_elapsed", 32'(cyc - t0), 32'(TMO));
      check("tmo_err", 32'(err_timeout), 32'd1);
      wait_req("tmo_stop_rise", 1'b1, 20);
      check("tmo_stop_op", 32'(op), 32'd4);
      auto_done = 1'b1;
      wait_idle("tmo_idle", 100);
      exp_count += 1;
      check("tmo_cmd_count", 32'(cmd_count), 32'(exp_count % 65536));
      pulse_clr();
      check("tmo_clr", 32'(err_timeout), 32'd0);
      run = 1'b0;
    end
`else
    check("no_timeout_flag", 32'(err_timeout), 32'd0);
`endif

    // Asynchronous reset while a command is in flight.
    auto_done = 1'b0;
    run = 1'b1;
    write_cmd(3'd1, 32'd42);
    write_cmd(3'd0, 32'd43);
    wait_req("rstmid_rise", 1'b1, 20);
    #3;
    RST = 1'b1;
    #1;
    check("rstmid_req", 32'(req), 32'd0);
    check("rstmid_level", 32'(level), 32'd0);
    check("rstmid_cmd_count", 32'(cmd_count), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    tick(1);
    RST = 1'b0;
    run = 1'b0;
    auto_done = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Command-queue stage directly upstream of the motor move block.
- Buffers motion commands (op, operand) written by a host-side decoder, such as a UART command parser, in a small FIFO.
- Issues commands one at a time over the move block's req/op/operand/done handshake.
- Handles abort by flushing the queue and issuing a stop command, and reports queue and error status.

Parameters:
- DEPTH, 8, FIFO depth in commands; power of two, 2..64.
- GAP_CYCLES, 16, idle cycles inserted after each completed command before the next issue; 0 means no gap.
- TIMEOUT_CYCLES, 50000000, maximum cycles in ISSUE waiting for done. Used only with MOVE_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- wr_en  in  1  push command into FIFO
- wr_op  in  3  command op: 0 fwd, 1 back, 2 left, 3 right, 4 stop; 5-7 invalid
- wr_operand  in  32  encoder-count distance or angle
- run  in  1  1 = dequeue and issue commands; 0 = hold queue, in-flight command completes
- abort  in  1  single-cycle pulse: flush queue, stop motors
- clr_err  in  1  clears sticky error flags
- req  out  1  to move block: command request
- op  out  3  to move block: command op
- operand  out  32  to move block: command operand
- done  in  1  from move block: command complete
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  state != IDLE
- cmd_count  out  16  completed commands, wraps at 65535->0
- err_ovf  out  1  sticky: write while full
- err_bad_op  out  1  sticky: invalid op dequeued
- err_timeout  out  1  sticky: done not seen within TIMEOUT_CYCLES

Behaviour:
- Reset (async, RST=1) values: state IDLE, FIFO empty, req=0, op=0, operand=0, empty=1, full=0, level=0, busy=0, cmd_count=0, all err flags 0. All outputs are registered.
- FIFO:
  - Write when wr_en && !full; a write while full is dropped and sets err_ovf.
  - Simultaneous push and pop are allowed when non-empty; level is then unchanged.
  - Pointers wrap modulo DEPTH.
- State IDLE:
  - If run && !empty: pop the head entry.
  - Valid op: load op/operand, set req=1, go to ISSUE.
  - Invalid op (5-7): discard, set err_bad_op, stay IDLE; the next pop may occur on the following cycle.
  - Latency: a write sampled at edge N into an empty FIFO with run=1 gives req=1 after edge N+2.
- ISSUE:
  - Hold req=1 with op/operand stable.
  - On done=1 sampled: req<=0, cmd_count++, go to RELEASE.
- RELEASE:
  - req=0. Wait for done=0. The move block needs req low to re-arm its request edge detector.
  - Then go to GAP, or to IDLE if GAP_CYCLES==0.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Abort (abort=1 in any state; highest priority):
  - Flush FIFO (level=0). A wr_en in the same cycle is dropped silently.
  - If IDLE with req=0: go to ABORT_STOP directly.
  - Otherwise: req<=0 and go to ABORT_DROP.
  - ABORT_DROP: hold req=0 for one cycle minimum and until done=0, then go to ABORT_STOP.
  - ABORT_STOP: op=4, operand=0, req=1, go to ISSUE. Completion follows the normal RELEASE/GAP path and increments cmd_count.
  - An abort during ABORT_DROP/ABORT_STOP re-flushes only; there is no re-entry.
- run deasserted mid-command does not cancel it; it only blocks the next pop in IDLE.
- clr_err clears all sticky flags. If a set condition occurs in the same cycle, the set wins.

Optional Feature:
- Macro: MOVE_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs while in ISSUE and resets on entry.
  - On reaching TIMEOUT_CYCLES without done: set err_timeout and perform the abort sequence (flush, ABORT_DROP, ABORT_STOP).
  - A timeout during the stop command itself sets err_timeout, drops req, and returns to IDLE with no retry.
- Undefined: no counter; ISSUE waits indefinitely; err_timeout is tied to 0.

Test Plan:
- Single command: run=1, write op=0 operand=1000; done model pulses 5 cycles after req -> req rises 2 cycles after write, op=0, operand=1000 stable; req falls after done; cmd_count=1; next req no earlier than GAP_CYCLES+1 cycles later.
- Queue ordering and full: write 9 commands with DEPTH=8, run=0 -> full=1, level=8, err_ovf=1. Then run=1 -> 8 commands issued in write order with the correct ops; cmd_count=8; empty=1.
- Invalid op: queue op=6 then op=1 operand=50 -> op=6 never appears on the bus, err_bad_op=1, op=1 issued. clr_err -> err_bad_op=0.
- Abort mid-command: 3 queued, abort during first ISSUE -> req drops, level=0, then req=1 with op=4, operand=0; after done, busy=0 and no further commands are issued.
- Reset mid-operation: assert RST while req=1 asynchronously -> req=0, level=0, cmd_count=0 immediately, with no clock edge required.
- Timeout (MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=100): done held 0 -> after 100 cycles err_timeout=1, req drops, then a stop command (op=4) is issued.
